// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg -- shared definitions for the iterative RV32M multiply/divide unit.
//   XLEN_DEFAULT : default operand/result width
//   op_e         : RV32M funct3 encodings (also used by the instruction decoder)
//   state_e      : sequencer states of muldiv_unit
//   op_is_div / op_signed_a / op_signed_b : operand interpretation helpers
// -----------------------------------------------------------------------------
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // funct3[2] separates the divide group from the multiply group.
  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // rs1 is treated as signed by MULH, MULHSU, DIV and REM.
  function automatic logic op_signed_a(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is treated as signed by MULH, DIV and REM.
  function automatic logic op_signed_b(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// -----------------------------------------------------------------------------
// muldiv_if -- request/response bundle between a pipeline (master) and
// muldiv_unit (slave).
//   start, kill, op, a, b        : master -> slave
//   busy, valid, result, illegal : slave  -> master
// -----------------------------------------------------------------------------
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) ();

  logic            start;
  logic            kill;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            valid;
  logic [XLEN-1:0] result;
  logic            illegal;

  modport master (
    output start, kill, op, a, b,
    input  busy, valid, result, illegal
  );

  modport slave (
    input  start, kill, op, a, b,
    output busy, valid, result, illegal
  );

endinterface

// File: rtl/muldiv_signfix.sv
// -----------------------------------------------------------------------------
// muldiv_signfix -- combinational conditional two's-complement negate.
// Used both to take operand magnitudes and to re-apply the result sign.
//   val : W-bit input value
//   neg : 1 = output the two's complement of val, 0 = pass through
//   res : W-bit output
// -----------------------------------------------------------------------------
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (W'(0) - val) : val;

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit -- iterative RV32M multiply/divide, one bit per cycle.
//   clk      : clock, all state on the rising edge
//   rst      : asynchronous active-high reset
//   bus      : muldiv_if.slave (start, kill, op, a, b / busy, valid, result,
//              illegal)
//
// Operands are reduced to magnitudes on the accepting edge, XLEN shift-add or
// restoring-divide steps run in CALC, and the sign is re-applied on the edge
// that enters DONE. valid (== DONE) is first sampled XLEN+1 edges after accept.
//
// Build option: define MULDIV_DIV_EN to include the divider. Without it the
// divide ops complete straight to DONE with illegal=1 and result=0.
// -----------------------------------------------------------------------------
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  localparam int CNT_W = $clog2(XLEN);

  state_e            state_q, state_d;
  logic              accept;
  logic              last_step;

  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   p_hi_q;      // product high half / partial remainder
  logic [XLEN-1:0]   p_lo_q;      // multiplier then product low / dividend then quotient
  logic [XLEN-1:0]   mb_q;        // |b|: multiplicand or divisor
  logic              neg_q;       // result must be negated
`ifdef MULDIV_DIV_EN
  logic              bz_q;        // divisor was zero
`endif

  logic [XLEN-1:0]   result_q;
  logic              illegal_q;

  // ---------------------------------------------------------------------------
  // Input conditioning: magnitudes and result sign, taken from the live bus.
  // ---------------------------------------------------------------------------
  logic              a_sign, b_sign, res_neg;
  logic [XLEN-1:0]   a_mag, b_mag;

  assign a_sign = op_signed_a(bus.op) & bus.a[XLEN-1];
  assign b_sign = op_signed_b(bus.op) & bus.b[XLEN-1];

`ifdef MULDIV_DIV_EN
  // Remainder follows the dividend; products and quotients follow a XOR b.
  assign res_neg = (op_is_div(bus.op) && bus.op[1]) ? a_sign : (a_sign ^ b_sign);
`else
  assign res_neg = a_sign ^ b_sign;
`endif

  muldiv_signfix #(.W(XLEN)) u_fix_a (.val(bus.a), .neg(a_sign), .res(a_mag));
  muldiv_signfix #(.W(XLEN)) u_fix_b (.val(bus.b), .neg(b_sign), .res(b_mag));

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registers take non-blocking (<=) so every flop samples pre-edge values.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_d   = state_q;
    accept    = 1'b0;
    last_step = 1'b0;
    bus.busy  = (state_q != S_IDLE);
    bus.valid = (state_q == S_DONE);

    unique case (state_q)
      S_IDLE: begin
        // kill outranks start: a killed request is never accepted.
        if (bus.start && !bus.kill) begin
          accept = 1'b1;
`ifdef MULDIV_DIV_EN
          state_d = S_CALC;
`else
          state_d = op_is_div(bus.op) ? S_DONE : S_CALC;
`endif
        end
      end
      S_CALC: begin
        if (bus.kill) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(XLEN - 1)) begin
          last_step = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // One iteration of the shared datapath.
  // ---------------------------------------------------------------------------
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   step_hi, step_lo;
`ifdef MULDIV_DIV_EN
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
`endif

  always_comb begin
    // Shift-add: conditionally add |b| into the high half, shift right as a pair.
    mul_sum = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, mb_q} : {(XLEN+1){1'b0}});
    step_hi = mul_sum[XLEN:1];
    step_lo = {mul_sum[0], p_lo_q[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
    // Restoring divide: shift the next dividend bit into the remainder and
    // subtract only if it fits. When it fits the difference is < |b|, so
    // XLEN-bit modular subtraction is exact.
    div_shift = {p_hi_q, p_lo_q[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, mb_q});
    div_diff  = div_shift[XLEN-1:0] - mb_q;
    if (op_is_div(op_q)) begin
      step_hi = div_ge ? div_diff : div_shift[XLEN-1:0];
      step_lo = {p_lo_q[XLEN-2:0], div_ge};
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Sign fix-up of the value produced by the final iteration.
  // ---------------------------------------------------------------------------
  logic [2*XLEN-1:0] fix_in, fix_out;
  logic [XLEN-1:0]   fin_result;

  always_comb begin
    fix_in = {step_hi, step_lo};
`ifdef MULDIV_DIV_EN
    if (op_is_div(op_q)) fix_in = {{XLEN{1'b0}}, (op_q[1] ? step_hi : step_lo)};
`endif
  end

  muldiv_signfix #(.W(2*XLEN)) u_fix_res (.val(fix_in), .neg(neg_q), .res(fix_out));

  always_comb begin
    fin_result = (op_q == OP_MUL) ? fix_out[XLEN-1:0] : fix_out[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
    // A zero divisor already yields an all-ones quotient and remainder |a|;
    // only the quotient must bypass the sign fix-up. Signed overflow
    // (most-negative / -1) needs no special case: |a| / 1 re-signed is a.
    if (op_is_div(op_q)) begin
      fin_result = (bz_q && !op_q[1]) ? {XLEN{1'b1}} : fix_out[XLEN-1:0];
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Working registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: working registers carry no reset; each is loaded on accept before use.
    if (accept) begin
      p_hi_q <= '0;
      p_lo_q <= a_mag;
      mb_q   <= b_mag;
      op_q   <= bus.op;
      neg_q  <= res_neg;
      cnt_q  <= '0;
`ifdef MULDIV_DIV_EN
      bz_q   <= (bus.b == '0);
`endif
    end else if (state_q == S_CALC) begin
      p_hi_q <= step_hi;
      p_lo_q <= step_lo;
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

  // Architecturally visible outputs; unchanged by kill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      // An accept that jumps straight to DONE is an unsupported op.
      illegal_q <= (state_d == S_DONE);
      if (state_d == S_DONE) result_q <= '0;
    end else if (last_step) begin
      result_q  <= fin_result;
    end
  end

  assign bus.result  = result_q;
  assign bus.illegal = illegal_q;

endmodule
